sequence_scheduler: RTL and testbench
=====================================

Name: sequence_scheduler

Overview:
- Programmable sequencer that drives the random-sequence counter.
- Holds a small table of target values. Walks the table in order and, for each entry, loads it into the counter, then waits until the counter's count reports that value.
- Clears the counter at sequence start and on abort. Optionally loops.
- Replaces hard-coded, delay-based sequencing with a clocked FSM and explicit handshakes.

Parameters:
- WIDTH, 3, width of count / target values
- DEPTH, 8, number of table entries
- IDX_W, 3, index width, equals clog2(DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cfg_we  input  1  table write strobe
- cfg_addr  input  IDX_W  table write address
- cfg_data  input  WIDTH  table write data
- cfg_len  input  IDX_W+1  number of valid entries, 1..DEPTH
- loop_en  input  1  wrap to entry 0 after the last entry
- start  input  1  begin sequence (level sampled, acts on one cycle)
- stop  input  1  abort sequence
- count  input  WIDTH  current counter value
- clear  output  1  counter synchronous clear
- in  output  WIDTH  target/load value to counter
- load  output  1  one-cycle load strobe for in
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse at sequence completion
- seq_idx  output  IDX_W  index of current entry

Behaviour:
- Reset (rst_n=0, async):
  - FSM=IDLE; table entries=0; len_q=0; seq_idx=0.
  - clear=1, in=0, load=0, busy=0, done=0.
- All outputs are registered.
- First clock after reset release: clear goes to 0 (IDLE drives clear=0).
- Table writes:
  - Accepted only in IDLE. cfg_we while busy is ignored.
  - cfg_addr >= DEPTH is ignored.
- FSM states: IDLE, CLEAR, LOAD, WAIT, DONE.
  - IDLE:
    - start=1 and cfg_len in 1..DEPTH → latch len_q=cfg_len and loop_q=loop_en; seq_idx=0; go CLEAR.
    - cfg_len=0 or cfg_len>DEPTH → start ignored.
  - CLEAR: clear=1 and busy=1 for exactly one cycle → LOAD.
  - LOAD: in=table[seq_idx], load=1 for one cycle → WAIT.
  - WAIT:
    - load=0. Stay until count==in (compared on the registered in).
    - On match with seq_idx<len_q-1 → seq_idx+1, then LOAD.
    - On match with seq_idx==len_q-1 and loop_q=1 → seq_idx=0, then LOAD. No clear on wrap.
    - On match with seq_idx==len_q-1 and loop_q=0 → DONE.
  - DONE: done=1 for one cycle, busy=0 → IDLE.
- Latency: start → clear at +1 cycle, first load at +2 cycles. Match → next load at +1 cycle.
- Repeated equal entries: each entry still issues its own load and waits for its own match. A match already present in the cycle after load counts.
- stop:
  - In any non-IDLE state: next state is IDLE, with clear=1 for one cycle, busy=0, done=0, seq_idx=0.
  - stop has priority over start, match and completion in the same cycle.
- start while busy: ignored.
- cfg_len / loop_en changes mid-sequence: no effect until the next start.
- Async reset mid-sequence: immediate return to reset values. The table is lost.
- busy=1 in CLEAR, LOAD and WAIT; 0 otherwise.
- Width rule: comparison is exact on WIDTH bits. seq_idx wraps only through the len_q check, never by modulo overflow.

Decomposition:
- Shared package seq_pkg holds:
  - the state enum (IDLE, CLEAR, LOAD, WAIT, DONE);
  - default WIDTH/DEPTH constants;
  - a localparam for the reset value of clear (1).
- One natural sub-module: seq_table, a DEPTH×WIDTH register file with a synchronous write port, combinational read and async clear. The FSM stays in sequence_scheduler.

Test Plan:
- Reset, then release → clear=1 during reset and 0 one cycle after release; in=0, busy=0, table reads 0.
- Write table {5,5,2,2,6,6}, cfg_len=6, loop_en=0, start; bench counter reaches each target 3 cycles after load → clear pulse once, then six load pulses with in=5,5,2,2,6,6 and seq_idx 0..5, then a single done pulse; busy falls with done.
- Same table with loop_en=1 and 14 matches → in sequence 5,5,2,2,6,6,5,5,2,2,6,6,5,5; no second clear; no done.
- Assert stop in WAIT at seq_idx=3 together with a count match → IDLE next cycle, clear=1 for one cycle, no load, done=0, seq_idx=0.
- cfg_len=0 plus start → stays IDLE, busy=0. cfg_we to address 2 while busy → table[2] unchanged after the run.
- Drop rst_n asynchronously mid-LOAD → load, busy and in go to 0 and clear to 1 without waiting for a clock edge; the table reads 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence scheduler: FSM states and default sizing.
package seq_pkg;
  localparam int DEF_WIDTH = 3;
  localparam int DEF_DEPTH = 8;
  localparam logic CLEAR_RST = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    WAIT,
    DONE
  } state_t;
endpackage

// File: rtl/seq_table.sv
// Target-value register file: synchronous write, combinational read, async clear.
module seq_table
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sequence_scheduler.sv
// Walks a table of counter targets: clear, then load each entry and wait for the
// counter to report it, optionally wrapping back to entry 0.
module sequence_scheduler
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [IDX_W:0]   cfg_len,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] count,
  output logic             clear,
  output logic [WIDTH-1:0] in,
  output logic             load,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] seq_idx
);

  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   LEN_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  state_t           state;
  logic [IDX_W:0]   len_q;
  logic             loop_q;
  logic             tbl_we;
  logic             len_ok;
  logic             match;
  logic             last;
  logic [IDX_W-1:0] next_idx;
  logic [IDX_W-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;

  assign tbl_we   = cfg_we && (state == IDLE) && ({1'b0, cfg_addr} < DEPTH_L);
  assign len_ok   = (cfg_len != '0) && (cfg_len <= DEPTH_L);
  assign match    = (count == in);
  assign last     = ({1'b0, seq_idx} == (len_q - LEN_ONE));
  assign next_idx = last ? '0 : seq_idx + IDX_ONE;
  // In WAIT the table is read one entry ahead so the next load is ready on the match edge.
  assign rd_addr  = (state == WAIT) ? next_idx : seq_idx;

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      len_q   <= '0;
      loop_q  <= 1'b0;
      seq_idx <= '0;
      clear   <= CLEAR_RST;
      in      <= '0;
      load    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (stop && (state != IDLE)) begin
      // Abort wins over every other event and leaves the counter cleared.
      state   <= IDLE;
      clear   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      load    <= 1'b0;
      seq_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          clear <= 1'b0;
          load  <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start && len_ok) begin
            len_q   <= cfg_len;
            loop_q  <= loop_en;
            seq_idx <= '0;
            clear   <= 1'b1;
            busy    <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          clear <= 1'b0;
          in    <= rd_data;
          load  <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          load  <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (match) begin
            if (last && !loop_q) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= DONE;
            end else begin
              seq_idx <= next_idx;
              in      <= rd_data;
              load    <= 1'b1;
              state   <= LOAD;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequence_scheduler.sv
// Bench for sequence_scheduler: cycle model compared every cycle plus directed literal checks.
module tb_sequence_scheduler;
  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic [IDX_W:0]   cfg_len = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic             clear;
  logic [WIDTH-1:0] in;
  logic             load;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] seq_idx;

  always #5 clk = ~clk;

  sequence_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len(cfg_len), .loop_en(loop_en), .start(start), .stop(stop), .count(count),
    .clear(clear), .in(in), .load(load), .busy(busy), .done(done), .seq_idx(seq_idx)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 clearing, 2 loading, 3 waiting, 4 finishing.
  int   m_tbl[DEPTH];
  int   m_len, m_ph, m_cur;
  bit   m_loop;
  logic e_clear = 1'b1;
  int   e_in = 0, e_idx = 0;
  bit   e_load = 0, e_busy = 0, e_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_len = 0; m_loop = 0;
      e_clear = 1'b1; e_in = 0; e_idx = 0; e_load = 0; e_busy = 0; e_done = 0;
      foreach (m_tbl[i]) m_tbl[i] = 0;
    end else begin
      m_cur = m_ph;
      if (m_cur != 0 && stop) begin
        m_ph = 0; e_clear = 1'b1; e_busy = 0; e_done = 0; e_load = 0; e_idx = 0;
      end else begin
        case (m_cur)
          0: begin
            e_clear = 1'b0; e_load = 0; e_done = 0; e_busy = 0;
            if (start && cfg_len >= 1 && cfg_len <= DEPTH) begin
              m_len = cfg_len; m_loop = loop_en; e_idx = 0;
              e_clear = 1'b1; e_busy = 1; m_ph = 1;
            end
          end
          1: begin e_clear = 1'b0; e_in = m_tbl[e_idx]; e_load = 1; m_ph = 2; end
          2: begin e_load = 0; m_ph = 3; end
          3: if (int'(count) == e_in) begin
               if (e_idx + 1 < m_len || m_loop) begin
                 e_idx = (e_idx + 1) % m_len; e_in = m_tbl[e_idx]; e_load = 1; m_ph = 2;
               end else begin
                 e_done = 1; e_busy = 0; m_ph = 4;
               end
             end
          default: begin e_done = 0; m_ph = 0; end
        endcase
      end
      if (m_cur == 0 && cfg_we && cfg_addr < DEPTH) m_tbl[cfg_addr] = int'(cfg_data);
    end
  end

  always @(negedge clk) begin
    check("clear", clear, e_clear);
    check("in", in, e_in);
    check("load", load, e_load);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("seq_idx", seq_idx, e_idx);
  end

  // Counter stand-in: after a load it shows a wrong value, then the target 3 cycles later.
  bit               auto_cnt = 1;
  logic [WIDTH-1:0] man_val = '0;
  int               c_delay = 0;
  logic [WIDTH-1:0] c_tgt = '0;
  always @(negedge clk) begin
    if (!auto_cnt) begin
      count = man_val; c_delay = 0;
    end else if (clear === 1'b1) begin
      count = '0; c_delay = 0;
    end else if (load === 1'b1) begin
      c_tgt = in; count = in + 3'd1; c_delay = 3;
    end else if (c_delay > 0) begin
      c_delay--;
      if (c_delay == 0) count = c_tgt;
    end
  end

  int ld_val[$];
  int ld_idx[$];
  int clr_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (load === 1'b1) begin ld_val.push_back(int'(in)); ld_idx.push_back(int'(seq_idx)); end
    if (rst_n && clear === 1'b1) clr_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic clear_logs();
    ld_val.delete(); ld_idx.delete(); clr_cnt = 0; done_cnt = 0;
  endtask

  task automatic write_tbl(input int addr, input int data);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = IDX_W'(addr); cfg_data = WIDTH'(data);
    @(negedge clk); cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int len, input bit lp);
    @(negedge clk); cfg_len = (IDX_W+1)'(len); loop_en = lp; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
    check(name, done, 1);
    check({name, "_busy"}, busy, 0);
    @(negedge clk);
  endtask

  task automatic wait_load(input int idx, input string name);
    int k = 0;
    while (!(load === 1'b1 && (idx < 0 || int'(seq_idx) == idx)) && k < 300) begin
      @(negedge clk); k++;
    end
    check(name, load, 1);
  endtask

  int exp6[6]   = '{5, 5, 2, 2, 6, 6};
  int exp3[3]   = '{5, 5, 2};
  int n_before;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_clear", clear, 1);
    check("rst_in", in, 0);
    check("rst_load", load, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", seq_idx, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_clear", clear, 0);

    // Fresh table reads zero.
    clear_logs(); pulse_start(2, 0); wait_done("t1_done");
    check("t1_nload", ld_val.size(), 2);
    for (int i = 0; i < ld_val.size(); i++) check("t1_val", ld_val[i], 0);

    // Linear run over {5,5,2,2,6,6}.
    for (int i = 0; i < 6; i++) write_tbl(i, exp6[i]);
    clear_logs(); pulse_start(6, 0); wait_done("t2_done");
    check("t2_nload", ld_val.size(), 6);
    for (int i = 0; i < 6 && i < ld_val.size(); i++) begin
      check("t2_val", ld_val[i], exp6[i]);
      check("t2_idx", ld_idx[i], i);
    end
    check("t2_clr", clr_cnt, 1);
    check("t2_donecnt", done_cnt, 1);

    // Looping run: 14 loads, no second clear, no done.
    clear_logs(); pulse_start(6, 1);
    for (int k = 0; k < 400 && ld_val.size() < 14; k++) @(negedge clk);
    check("t3_nload", ld_val.size() >= 14, 1);
    for (int i = 0; i < 14 && i < ld_val.size(); i++) check("t3_val", ld_val[i], exp6[i % 6]);
    check("t3_clr", clr_cnt, 1);
    check("t3_donecnt", done_cnt, 0);
    @(negedge clk); stop = 1'b1; @(negedge clk); stop = 1'b0;
    check("t3_stop_busy", busy, 0);
    repeat (2) @(negedge clk);

    // Stop in WAIT at index 3 together with a count match.
    clear_logs(); pulse_start(6, 0);
    wait_load(3, "t4_reach3");
    @(posedge clk); #1 man_val = in; auto_cnt = 0;
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    check("t4_clear", clear, 1);
    check("t4_busy", busy, 0);
    check("t4_load", load, 0);
    check("t4_done", done, 0);
    check("t4_idx", seq_idx, 0);
    n_before = ld_val.size();
    @(negedge clk);
    check("t4_clear_drop", clear, 0);
    auto_cnt = 1;
    repeat (3) @(negedge clk);
    check("t4_noload", ld_val.size(), n_before);
    check("t4_nodone", done_cnt, 0);

    // Invalid lengths are ignored.
    pulse_start(0, 0); @(negedge clk);
    check("t5_len0_busy", busy, 0);
    pulse_start(9, 0); @(negedge clk);
    check("t5_len9_busy", busy, 0);

    // Table write and loop_en change during a run have no effect.
    clear_logs(); pulse_start(6, 0);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 3'd7; loop_en = 1'b1;
    @(negedge clk); cfg_we = 1'b0;
    wait_done("t5_done");
    clear_logs(); pulse_start(3, 0); wait_done("t5b_done");
    check("t5b_nload", ld_val.size(), 3);
    for (int i = 0; i < 3 && i < ld_val.size(); i++) check("t5b_val", ld_val[i], exp3[i]);

    // Asynchronous reset while a load is on the outputs.
    clear_logs(); pulse_start(6, 0);
    wait_load(-1, "t6_load_seen");
    #2 rst_n = 1'b0;
    #1;
    check("t6_load", load, 0);
    check("t6_busy", busy, 0);
    check("t6_in", in, 0);
    check("t6_clear", clear, 1);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    clear_logs(); pulse_start(3, 0); wait_done("t6_done");
    check("t6_nload", ld_val.size(), 3);
    for (int i = 0; i < ld_val.size(); i++) check("t6_val", ld_val[i], 0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
